// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone B4 classic arbiter, N masters onto one slave.
// Optional response watchdog enabled by defining WB_ARBITER_TIMEOUT_EN.
module wb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [31:0]               s_adr_o,
  output logic [3:0]                s_sel_o,
  output logic [31:0]               s_dat_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  output logic [NUM_MASTERS-1:0]    gnt_o,
  output logic                      busy_o
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("wb_arbiter: parameter out of range");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   w_owner_n;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_ptr_n;
  logic [N-1:0]    r_gnt;
  logic [N-1:0]    w_gnt_n;

  logic [N-1:0]    w_hi;
  logic [IW-1:0]   w_pick;
  logic            w_busy;
  logic            w_cyc;
  logic            w_stb;
  logic            w_we;
  logic [31:0]     w_adr;
  logic [3:0]      w_sel;
  logic [31:0]     w_dat;
  logic            w_to;
  logic [N-1:0]    w_rsp_en;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall.
  always_comb begin
    w_hi   = m_cyc_i & ({N{1'b1}} << r_ptr);
    w_pick = '0;
    for (int k = N-1; k >= 0; k--)
      if (m_cyc_i[k]) w_pick = IW'(k);
    for (int k = N-1; k >= 0; k--)
      if (w_hi[k]) w_pick = IW'(k);
  end

  // Owner mux: route the registered owner's request signals.
  always_comb begin
    w_cyc = 1'b0;
    w_stb = 1'b0;
    w_we  = 1'b0;
    w_adr = '0;
    w_sel = '0;
    w_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (r_owner == IW'(k)) begin
        w_cyc = m_cyc_i[k];
        w_stb = m_stb_i[k];
        w_we  = m_we_i[k];
        w_adr = m_adr_i[32*k +: 32];
        w_sel = m_sel_i[4*k +: 4];
        w_dat = m_dat_i[32*k +: 32];
      end
    end
  end

  // Next-state: grant from idle, hold for the whole cyc burst.
  always_comb begin
    w_state_n = r_state;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
    w_gnt_n   = r_gnt;
    unique case (r_state)
      S_IDLE: begin
        if (|m_cyc_i) begin
          w_state_n = S_BUSY;
          w_owner_n = w_pick;
          w_gnt_n   = N'(1) << w_pick;
          w_ptr_n   = (w_pick == IW'(N-1)) ? '0 : w_pick + IW'(1);
        end
      end
      S_BUSY: begin
        if (!w_cyc) begin
          w_state_n = S_IDLE;
          w_gnt_n   = '0;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_gnt_n   = '0;
      end
    endcase
  end

  // State, owner, pointer and grant registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_owner <= w_owner_n;
      r_ptr   <= w_ptr_n;
      r_gnt   <= w_gnt_n;
    end
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        w_resp;
  logic        w_stall;

  assign w_resp  = s_ack_i | s_err_i | s_rty_i;
  assign w_stall = w_busy & w_cyc & w_stb & ~w_resp;
  assign w_to    = w_busy & (r_cnt == 16'(TIMEOUT_CYCLES));

  // Watchdog: count strobed cycles with no slave response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_cnt <= '0;
    else if (!w_stall || w_to)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 16'd1;
  end
`else
  assign w_to = 1'b0;
`endif

  assign w_busy   = (r_state == S_BUSY);
  // A released owner never sees a late response.
  assign w_rsp_en = r_gnt & {N{w_cyc}};

  assign s_cyc_o  = w_busy & w_cyc & ~w_to;
  assign s_stb_o  = w_busy & w_cyc & w_stb & ~w_to;
  assign s_we_o   = w_busy & w_we;
  assign s_adr_o  = w_busy ? w_adr : '0;
  assign s_sel_o  = w_busy ? w_sel : '0;
  assign s_dat_o  = w_busy ? w_dat : '0;

  assign m_dat_o  = s_dat_i;
  assign m_ack_o  = w_rsp_en & {N{s_ack_i}};
  assign m_err_o  = w_rsp_en & {N{s_err_i | w_to}};
  assign m_rty_o  = w_rsp_en & {N{s_rty_i}};

  assign gnt_o    = r_gnt;
  assign busy_o   = w_busy;

endmodule
